// File: rtl/split_access_ctrl_pkg.sv
// Shared encodings for the split-access controller: FSM state codes and completion fault codes.
package split_access_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] fault_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam fault_t FLT_OK   = 2'd0;
    localparam fault_t FLT_TLB  = 2'd1;
    localparam fault_t FLT_PROT = 2'd2;
    localparam fault_t FLT_TO   = 2'd3;

    // Protection outranks a TLB miss when both are flagged on the same request.
    function automatic fault_t classify_fault(input logic tlb_miss, input logic prot_exc);
        if (prot_exc) return FLT_PROT;
        if (tlb_miss) return FLT_TLB;
        return FLT_OK;
    endfunction

endpackage

// File: rtl/split_access_ctrl_if.sv
// Pipeline request/completion handshake plus the even/odd bank request channels.
interface split_access_ctrl_if;
    import split_access_ctrl_pkg::*;

    logic   in_valid;
    logic   in_ready;
    logic   in_needP1;
    logic   in_bank0;
    logic   in_w;
    logic   in_sw;
    logic   in_tlb_miss;
    logic   in_prot_exc;
    logic   even_req;
    logic   odd_req;
    logic   even_ack;
    logic   odd_ack;
    logic   even_done;
    logic   odd_done;
    logic   req_w;
    logic   req_sw;
    logic   out_valid;
    logic   out_ready;
    fault_t out_fault;
    logic   busy;

    modport slave (
        input  in_valid, in_needP1, in_bank0, in_w, in_sw, in_tlb_miss, in_prot_exc,
        input  even_ack, odd_ack, even_done, odd_done, out_ready,
        output in_ready, even_req, odd_req, req_w, req_sw, out_valid, out_fault, busy
    );

    modport master (
        output in_valid, in_needP1, in_bank0, in_w, in_sw, in_tlb_miss, in_prot_exc,
        output even_ack, odd_ack, even_done, odd_done, out_ready,
        input  in_ready, even_req, odd_req, req_w, req_sw, out_valid, out_fault, busy
    );

endinterface

// File: rtl/split_access_ctrl_bank_track.sv
// Per-bank half tracker: holds the request until ack, then records the matching done pulse.
module bank_track (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic need,
    input  logic ack,
    input  logic done,
    input  logic clear,
    output logic req,
    output logic acked,
    output logic finished
);

    logic need_q, need_d;
    logic acked_q, acked_d;
    logic finished_q, finished_d;
    logic acked_now;
    logic done_hit;

    assign req       = need_q & ~acked_q;
    assign acked_now = acked_q | (req & ack);
    // A done counts only once this half has been accepted, possibly by an ack in the same cycle.
    assign done_hit  = need_q & acked_now & done;

    // An unneeded half reports itself acked and finished so the FSM can AND both banks.
    assign acked     = ~need_q | acked_now;
    assign finished  = ~need_q | finished_q | done_hit;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        need_d     = need_q;
        acked_d    = acked_q;
        finished_d = finished_q;
        if (clear) begin
            need_d     = 1'b0;
            acked_d    = 1'b0;
            finished_d = 1'b0;
        end else if (start) begin
            need_d     = need;
            acked_d    = 1'b0;
            finished_d = 1'b0;
        end else begin
            acked_d    = acked_now;
            finished_d = finished_q | done_hit;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            need_q     <= 1'b0;
            acked_q    <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            need_q     <= need_d;
            acked_q    <= acked_d;
            finished_q <= finished_d;
        end
    end

endmodule

// File: rtl/split_access_ctrl.sv
// Sequences one aligned or line-split cache access across the even/odd banks and returns one completion.
module split_access_ctrl
    import split_access_ctrl_pkg::*;
#(
    parameter int TO_W   = 8,
    parameter int TO_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    split_access_ctrl_if.slave   bus
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_MAX);
    localparam bit              TO_EN    = (TO_MAX != 0);

    state_t            state_q, state_d;
    fault_t            fault_q, fault_d;
    logic              w_q, w_d;
    logic              sw_q, sw_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    logic              start;
    logic              clear;
    logic              need_even;
    logic              need_odd;
    logic              even_acked, odd_acked;
    logic              even_finished, odd_finished;
    logic              all_acked;
    logic              all_finished;

    assign need_even    = ~bus.in_bank0 | bus.in_needP1;
    assign need_odd     =  bus.in_bank0 | bus.in_needP1;
    assign all_acked    = even_acked & odd_acked;
    assign all_finished = even_finished & odd_finished;

    bank_track u_even (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .need     (need_even),
        .ack      (bus.even_ack),
        .done     (bus.even_done),
        .clear    (clear),
        .req      (bus.even_req),
        .acked    (even_acked),
        .finished (even_finished)
    );

    bank_track u_odd (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .need     (need_odd),
        .ack      (bus.odd_ack),
        .done     (bus.odd_done),
        .clear    (clear),
        .req      (bus.odd_req),
        .acked    (odd_acked),
        .finished (odd_finished)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        w_d     = w_q;
        sw_d    = sw_q;
        cnt_d   = '0;
        start   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_d     = bus.in_w;
                    sw_d    = bus.in_sw;
                    fault_d = classify_fault(bus.in_tlb_miss, bus.in_prot_exc);
                    if (fault_d == FLT_OK) begin
                        start   = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                if (all_finished) begin
                    clear   = 1'b1;
                    state_d = ST_RESP;
                end else if (all_acked) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + TO_W'(1);
                // Clearing the trackers on timeout makes any late done from an abandoned half harmless.
                if (all_finished) begin
                    clear   = 1'b1;
                    state_d = ST_RESP;
                end else if (TO_EN && (cnt_q == TO_LIMIT)) begin
                    clear   = 1'b1;
                    fault_d = FLT_TO;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fault_q <= FLT_OK;
            w_q     <= 1'b0;
            sw_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            w_q     <= w_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are pure decodes of registered state.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_RESP);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_fault = fault_q;
    assign bus.req_w     = w_q;
    assign bus.req_sw    = sw_q;

endmodule

// File: tb/tb_split_access_ctrl.sv
// Directed bench for split_access_ctrl: aligned, split, faults, timeout, backpressure and mid-op reset.
module tb_split_access_ctrl;
    import split_access_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    split_access_ctrl_if bus ();

    split_access_ctrl #(
        .TO_W   (8),
        .TO_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid    = 1'b0;
        bus.in_needP1   = 1'b0;
        bus.in_bank0    = 1'b0;
        bus.in_w        = 1'b0;
        bus.in_sw       = 1'b0;
        bus.in_tlb_miss = 1'b0;
        bus.in_prot_exc = 1'b0;
        bus.even_ack    = 1'b0;
        bus.odd_ack     = 1'b0;
        bus.even_done   = 1'b0;
        bus.odd_done    = 1'b0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  1);
        check({tag, "_even_req"},  32'(bus.even_req),  0);
        check({tag, "_odd_req"},   32'(bus.odd_req),   0);
        check({tag, "_req_w"},     32'(bus.req_w),     0);
        check({tag, "_req_sw"},    32'(bus.req_sw),    0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_fault"}, 32'(bus.out_fault), 0);
        check({tag, "_busy"},      32'(bus.busy),      0);
    endtask

    task automatic request(input logic bank0, input logic needp1, input logic w, input logic sw,
                           input logic tlb, input logic prot);
        bus.in_valid    = 1'b1;
        bus.in_bank0    = bank0;
        bus.in_needP1   = needp1;
        bus.in_w        = w;
        bus.in_sw       = sw;
        bus.in_tlb_miss = tlb;
        bus.in_prot_exc = prot;
    endtask

    // Complete the RESP handshake and confirm the return to IDLE.
    task automatic take_response(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_idle_ready"}, 32'(bus.in_ready),  1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_reset_values("rst");
        rst = 1'b0;
        tick();
        check_reset_values("post_rst");

        // Aligned even read: ack and done at T+1 -> out_valid at T+2.
        request(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        check("al_even_req_t1", 32'(bus.even_req), 1);
        check("al_odd_req_t1",  32'(bus.odd_req),  0);
        check("al_busy_t1",     32'(bus.busy),     1);
        check("al_ready_t1",    32'(bus.in_ready), 0);
        check("al_valid_t1",    32'(bus.out_valid), 0);
        bus.even_ack  = 1'b1;
        bus.even_done = 1'b1;
        tick();
        clear_inputs();
        check("al_valid_t2",    32'(bus.out_valid), 1);
        check("al_fault_t2",    32'(bus.out_fault), FLT_OK);
        check("al_even_req_t2", 32'(bus.even_req),  0);
        check("al_odd_req_t2",  32'(bus.odd_req),   0);
        take_response("al");

        // Split, odd first: odd ack T+1, early even done T+2 ignored, even ack T+3, odd done T+4, even done T+5.
        request(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        check("sp_even_req_t1", 32'(bus.even_req), 1);
        check("sp_odd_req_t1",  32'(bus.odd_req),  1);
        check("sp_req_w_t1",    32'(bus.req_w),    1);
        check("sp_req_sw_t1",   32'(bus.req_sw),   0);
        bus.odd_ack = 1'b1;
        tick();
        clear_inputs();
        check("sp_odd_req_t2",  32'(bus.odd_req),  0);
        check("sp_even_req_t2", 32'(bus.even_req), 1);
        bus.even_done = 1'b1;
        tick();
        clear_inputs();
        check("sp_valid_t3",    32'(bus.out_valid), 0);
        check("sp_even_req_t3", 32'(bus.even_req),  1);
        bus.even_ack = 1'b1;
        tick();
        clear_inputs();
        check("sp_even_req_t4", 32'(bus.even_req),  0);
        check("sp_valid_t4",    32'(bus.out_valid), 0);
        bus.odd_done = 1'b1;
        tick();
        clear_inputs();
        check("sp_valid_t5",    32'(bus.out_valid), 0);
        bus.even_done = 1'b1;
        tick();
        clear_inputs();
        check("sp_valid_t6",    32'(bus.out_valid), 1);
        check("sp_fault_t6",    32'(bus.out_fault), FLT_OK);
        take_response("sp");

        // Protection and TLB miss together: protection wins, no bank request.
        request(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        clear_inputs();
        check("pf_valid_t1",    32'(bus.out_valid), 1);
        check("pf_fault_t1",    32'(bus.out_fault), FLT_PROT);
        check("pf_even_req_t1", 32'(bus.even_req),  0);
        check("pf_odd_req_t1",  32'(bus.odd_req),   0);
        take_response("pf");

        // TLB miss with 3 cycles of backpressure while a new request waits on in_valid.
        request(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        clear_inputs();
        request(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid_hold", 32'(bus.out_valid), 1);
            check("bp_fault_hold", 32'(bus.out_fault), FLT_TLB);
            check("bp_ready_hold", 32'(bus.in_ready),  0);
            check("bp_even_req",   32'(bus.even_req),  0);
            if (i == 2) bus.out_ready = 1'b1;
            tick();
        end
        bus.out_ready = 1'b0;
        check("bp_idle_ready",    32'(bus.in_ready),  1);
        check("bp_idle_valid",    32'(bus.out_valid), 0);
        check("bp_idle_even_req", 32'(bus.even_req),  0);
        tick();
        clear_inputs();
        check("bp_acc_even_req",  32'(bus.even_req), 1);
        check("bp_acc_req_sw",    32'(bus.req_sw),   1);
        bus.even_ack  = 1'b1;
        bus.even_done = 1'b1;
        tick();
        clear_inputs();
        check("bp_acc_valid",     32'(bus.out_valid), 1);
        check("bp_acc_fault",     32'(bus.out_fault), FLT_OK);
        take_response("bp");

        // Timeout: even acked, never done; WAIT entered at E -> fault 3 at E+5.
        request(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        check("to_even_req_t1", 32'(bus.even_req), 1);
        bus.even_ack = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            check("to_wait_valid", 32'(bus.out_valid), 0);
            check("to_wait_busy",  32'(bus.busy),      1);
            tick();
        end
        check("to_valid", 32'(bus.out_valid), 1);
        check("to_fault", 32'(bus.out_fault), FLT_TO);
        bus.even_done = 1'b1;
        tick();
        clear_inputs();
        check("to_late_valid", 32'(bus.out_valid), 1);
        check("to_late_fault", 32'(bus.out_fault), FLT_TO);
        take_response("to");
        bus.even_done = 1'b1;
        tick();
        clear_inputs();
        check("to_idle_valid", 32'(bus.out_valid), 0);
        check("to_idle_busy",  32'(bus.busy),      0);

        // Reset pulse in WAIT: outputs return to reset values at once; later dones are ignored.
        request(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        clear_inputs();
        bus.even_ack = 1'b1;
        bus.odd_ack  = 1'b1;
        tick();
        clear_inputs();
        check("rw_busy_wait",   32'(bus.busy),   1);
        check("rw_req_sw_wait", 32'(bus.req_sw), 1);
        rst = 1'b1;
        #1;
        check_reset_values("rw_async");
        tick();
        rst = 1'b0;
        bus.even_done = 1'b1;
        bus.odd_done  = 1'b1;
        tick();
        clear_inputs();
        check("rw_done_valid", 32'(bus.out_valid), 0);
        tick();
        check_reset_values("rw_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/split_access_ctrl.md
# split_access_ctrl

- Sequences one memory-stage cache access, aligned or line-split, across the even and odd cache banks.
- Sits between the input-align/TLB stage and the two bank controllers.
- Per request, it:
  - accepts the request with a valid/ready handshake;
  - diverts TLB misses and protection faults;
  - issues each needed half to its bank;
  - waits for both halves to complete;
  - returns a single completion, with a fault code, to the pipeline.

## Interface
Parameters:
- TO_W, 8, width of the wait-timeout counter.
- TO_MAX, 255, cycles in WAIT before timeout fault; 0 disables timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept.
- in_needP1  in  1  access spans two lines.
- in_bank0  in  1  bank of first half (address0[4]); 0 = even, 1 = odd.
- in_w  in  1  write access.
- in_sw  in  1  store-with-wake access.
- in_tlb_miss  in  1  TLB miss for either half.
- in_prot_exc  in  1  protection exception for either half.
- even_req, odd_req  out  1  bank request; held until ack.
- even_ack, odd_ack  in  1  bank accepted request.
- even_done, odd_done  in  1  bank finished its half; single-cycle pulse.
- req_w, req_sw  out  1  latched in_w / in_sw; valid while any req is high.
- out_valid  out  1  completion present.
- out_ready  in  1  pipeline takes completion.
- out_fault  out  2  completion code: 0 ok, 1 TLB miss, 2 protection, 3 timeout.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch needP1, bank0, w, sw.
  - need_even = (bank0==0) | needP1; need_odd = (bank0==1) | needP1.
  - If in_prot_exc: fault = 2, go to RESP. Protection wins over miss.
  - Else if in_tlb_miss: fault = 1, go to RESP.
  - Otherwise: fault = 0, go to ISSUE.
- ISSUE:
  - Drive x_req for each needed bank whose ack is not yet seen.
  - x_req drops the cycle after x_ack.
  - Go to WAIT when every needed bank has acked.
- Done tracking: a done is recorded when the bank is needed and has acked by that cycle, including an ack in the same cycle. Any other done is ignored.
- WAIT:
  - When every needed bank has recorded done, go to RESP.
  - Timeout counter starts at 0 on WAIT entry and increments each WAIT cycle.
  - If TO_MAX != 0 and the counter reaches TO_MAX, set fault = 3, go to RESP, and abandon outstanding halves.
  - A done arriving after a timeout is ignored.
- RESP:
  - out_valid = 1; out_fault is stable.
  - Go to IDLE on out_ready.
  - in_ready = 0, so no back-to-back accept; the next accept happens in IDLE.
- If all needed halves complete in the ISSUE cycle, go directly from ISSUE to RESP.

## Timing
- Reset values: in_ready 1, even_req 0, odd_req 0, req_w 0, req_sw 0, out_valid 0, out_fault 0, busy 0. All tracking bits and the counter are 0.
- Reset mid-operation:
  - Immediate abandonment; outstanding bank transactions are not cancelled.
  - Any bank done arriving after reset is ignored.
- Accept at cycle T; x_req high at T+1.
- Minimum ok latency: out_valid at T+2, when ack and done both arrive at T+1.
- Fault latency: out_valid at T+1.
- in_ready, out_valid and x_req are registered-state decodes only. No combinational path from in_valid, ack or done to these outputs.
- Split accesses issue both banks in the same cycle; the banks may ack and complete in either order.

## Structure
- Shared package holds:
  - state encoding (2 bits);
  - fault codes FLT_OK = 0, FLT_TLB = 1, FLT_PROT = 2, FLT_TO = 3.
- Sub-module bank_track, instantiated twice (even, odd):
  - inputs: clk, rst, start, need, ack, done, clear;
  - outputs: req, acked, finished.
- Top level: FSM, latches, timeout counter.

## Test plan
- Aligned even-bank read: in_bank0 = 0, needP1 = 0; even_ack and even_done at T+1 -> out_valid at T+2, out_fault = 0, odd_req never asserted.
- Split access: bank0 = 1, needP1 = 1; odd ack at T+1 and done at T+4; even ack at T+3 and done at T+2 (the T+2 done is ignored), then even done at T+5 -> both reqs high at T+1, out_valid at T+6.
- Faults:
  - in_tlb_miss = 1 and in_prot_exc = 1 together -> out_fault = 2 at T+1, no bank req.
  - in_tlb_miss only -> out_fault = 1.
- Timeout: TO_MAX = 4; even acked, never done -> out_fault = 3 at WAIT entry + 5; a late even_done is then ignored.
- Backpressure: out_ready held 0 for 3 cycles -> out_valid and out_fault stable; in_valid is not accepted until the cycle after the out_ready handshake.
- rst pulse asserted in WAIT -> all outputs return to reset values immediately; a subsequent even_done does not produce out_valid.
